keypad_scan_ctrl: RTL

Scan controller for the 4x4 matrix keypad. It drives the active-low column strobes and samples the active-low row lines. It debounces presses, converts each confirmed press into a 4-bit key code and queues the codes in a small FIFO. Downstream logic (display / LED driver) pops the codes through a valid/ready handshake.

---
 rtl/keypad_pkg.sv | 45 ++++
 rtl/keypad_scan_ctrl_if.sv | 9 +
 rtl/key_fifo.sv | 51 +++++
 rtl/keypad_scan_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, FSM state codes and line decoding for the 4x4 keypad scanner.
package keypad_pkg;

   localparam logic [3:0] C1   = 4'b0111;
   localparam logic [3:0] C2   = 4'b1011;
   localparam logic [3:0] C3   = 4'b1101;
   localparam logic [3:0] C4   = 4'b1110;
   localparam logic [3:0] IDLE = 4'b1111;

   localparam logic [1:0] SCAN     = 2'd0;
   localparam logic [1:0] DEBOUNCE = 2'd1;
   localparam logic [1:0] HOLD     = 2'd2;

   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
   } line_dec_t;

   // A line pattern is valid only with exactly one low bit; ghosts and idle read as invalid.
   function automatic line_dec_t decode_line(input logic [3:0] v);
      line_dec_t d;
      d.valid = 1'b1;
      d.idx   = 2'd0;
      case (v)
         C1:      d.idx = 2'd0;
         C2:      d.idx = 2'd1;
         C3:      d.idx = 2'd2;
         C4:      d.idx = 2'd3;
         default: d.valid = 1'b0;
      endcase
      return d;
   endfunction

   function automatic logic [3:0] col_strobe(input logic [1:0] idx);
      logic [3:0] s;
      case (idx)
         2'd0:    s = C1;
         2'd1:    s = C2;
         2'd2:    s = C3;
         default: s = C4;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Key-code stream between the scanner (master) and its consumer (slave).
interface keypad_scan_ctrl_if #(parameter int W = 4);
   logic [W-1:0] key_code;
   logic         key_valid;
   logic         key_ready;

   modport master (output key_code, output key_valid, input key_ready);
   modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/key_fifo.sv
// Show-ahead FIFO with valid/ready pop; head and valid come straight from registers.
module key_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   output logic [WIDTH-1:0] head,
   output logic             valid,
   input  logic             ready
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign valid   = (count != '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign head    = mem[rptr];
   assign do_pop  = valid && ready;
   // When full, a push is still accepted if the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= push_data;
            wptr      <= wptr + 1'b1;
         end
         if (do_pop) rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column strobing, row synchronisation, debounce FSM and key-code queue.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [3:0]         row,
   output logic [3:0]         col,
   output logic               pressed,
   output logic               overflow,
   input  logic               clr_ovf,
   keypad_scan_ctrl_if.master kif
);
   import keypad_pkg::*;

   localparam int CW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CNT - 1);

   logic [3:0]    rs_meta;
   logic [3:0]    rs;
   logic [CW-1:0] dwell;
   logic [DW-1:0] deb;
   logic [1:0]    state;
   logic [1:0]    col_idx;
   logic [3:0]    cand;
   logic          push_q;
   logic          sample;
   logic          fifo_full;
   logic          drop;
   logic [3:0]    fifo_head;
   logic          fifo_valid;
   line_dec_t     rdec;

   assign rdec    = decode_line(rs);
   assign sample  = en && (dwell == DWELL_LAST);
   assign col     = en ? col_strobe(col_idx) : IDLE;
   assign pressed = (state == HOLD);

   always_ff @(posedge clk) begin
      if (rst) begin
         rs_meta <= IDLE;
         rs      <= IDLE;
      end else begin
         rs_meta <= row;
         rs      <= rs_meta;
      end
   end

   // Column stays frozen outside SCAN so that debounce and release look at the same key.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         state   <= SCAN;
         dwell   <= '0;
         deb     <= '0;
         col_idx <= 2'd0;
         cand    <= 4'd0;
         push_q  <= 1'b0;
      end else begin
         push_q <= 1'b0;
         dwell  <= sample ? '0 : dwell + 1'b1;
         if (sample) begin
            case (state)
               SCAN: begin
                  if (rdec.valid) begin
                     cand  <= {col_idx, rdec.idx};
                     deb   <= DW'(1);
                     state <= DEBOUNCE;
                  end else begin
                     col_idx <= col_idx + 2'd1;
                  end
               end
               DEBOUNCE: begin
                  if (rdec.valid && rdec.idx == cand[1:0]) begin
                     if (deb == DEB_LAST) begin
                        push_q <= 1'b1;
                        deb    <= '0;
                        state  <= HOLD;
                     end else begin
                        deb <= deb + 1'b1;
                     end
                  end else begin
                     deb     <= '0;
                     state   <= SCAN;
                     col_idx <= col_idx + 2'd1;
                  end
               end
               HOLD: begin
                  if (rdec.valid) begin
                     deb <= '0;
                  end else if (deb == DEB_LAST) begin
                     deb     <= '0;
                     state   <= SCAN;
                     col_idx <= col_idx + 2'd1;
                  end else begin
                     deb <= deb + 1'b1;
                  end
               end
               default: state <= SCAN;
            endcase
         end
      end
   end

   assign drop = push_q && fifo_full && !(fifo_valid && kif.key_ready);

   // A new drop outranks a simultaneous clear so no lost key goes unreported.
   always_ff @(posedge clk) begin
      if (rst)          overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
   end

   key_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(4)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_q),
      .push_data (cand),
      .full      (fifo_full),
      .head      (fifo_head),
      .valid     (fifo_valid),
      .ready     (kif.key_ready)
   );

   assign kif.key_code  = fifo_head;
   assign kif.key_valid = fifo_valid;

endmodule
